// File: rtl/sm83_pkg.sv
// rtl/sm83_pkg.sv - shared SM83 types and constants
package sm83_pkg;

    localparam int          SM83_PC_W        = 16;
    localparam logic [15:0] SM83_RESET_PC    = 16'h0000;
    localparam int          SM83_SRAM_RD_LAT = 1;

    typedef logic [7:0] sm83_opcode_t;

endpackage

// File: rtl/sm83_byte_fifo.sv
// rtl/sm83_byte_fifo.sv - tagged byte queue with flush for the prefetcher
module sm83_byte_fifo
    import sm83_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = SM83_PC_W
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     push,
    input  sm83_opcode_t             push_data,
    input  logic [TAG_W-1:0]         push_tag,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output sm83_opcode_t             head_data,
    output logic [TAG_W-1:0]         head_tag
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sm83_opcode_t     data_q [DEPTH];
    sm83_opcode_t     data_d [DEPTH];
    logic [TAG_W-1:0] tag_q  [DEPTH];
    logic [TAG_W-1:0] tag_d  [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    // A pop against an empty queue is silently dropped.
    assign do_pop = pop && (count_q != '0);

    always_comb begin
        data_d   = data_q;
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                data_d[wr_ptr_q] = push_data;
                tag_d[wr_ptr_q]  = push_tag;
                wr_ptr_d         = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            data_q   <= data_d;
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            assert (32'(count_q) <= DEPTH);
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != '0);
    assign head_data  = data_q[rd_ptr_q];
    assign head_tag   = tag_q[rd_ptr_q];

endmodule

// File: rtl/sm83_prefetch_unit.sv
// rtl/sm83_prefetch_unit.sv - pipelined SM83 instruction-byte prefetcher
module sm83_prefetch_unit
    import sm83_pkg::*;
#(
    parameter int              ADDR_W   = 13,
    parameter int              PC_W     = SM83_PC_W,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(SM83_RESET_PC)
) (
    input  logic              CLOCK,
    input  logic              RESET,
    output logic [ADDR_W-1:0] SRAM_ADDRESS,
    output logic              SRAM_RD,
    input  logic [7:0]        SRAM_Q,
    input  logic              BUS_GRANT,
    input  logic              REDIRECT_VALID,
    input  logic [PC_W-1:0]   REDIRECT_PC,
    output logic              OP_VALID,
    output logic [7:0]        OP_BYTE,
    output logic [PC_W-1:0]   OP_PC,
    input  logic              OP_READY,
    output logic [PC_W-1:0]   FETCH_PC,
    output logic [7:0]        DEBUG_LAST_OPCODE
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [PC_W-1:0]  inflight_pc_q, inflight_pc_d;
    sm83_opcode_t     last_op_q, last_op_d;

    logic [CNT_W-1:0] fifo_count;
    logic             head_valid;
    sm83_opcode_t     head_data;
    logic [PC_W-1:0]  head_tag;
    logic             credit_ok;
    logic             pop_fire;
    logic             push;

    // Conservative credit: a same-cycle pop is not counted, so the slot for
    // every in-flight byte is reserved before its read is issued.
    assign credit_ok = ({1'b0, fifo_count} + (CNT_W + 1)'(inflight_q)) < (CNT_W + 1)'(DEPTH);
    assign SRAM_RD   = RESET && BUS_GRANT && !REDIRECT_VALID && credit_ok;
    assign pop_fire  = head_valid && OP_READY;
    assign push      = inflight_q && !REDIRECT_VALID;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        last_op_d     = last_op_q;
        if (pop_fire) begin
            last_op_d = head_data;
        end
        if (REDIRECT_VALID) begin
            fetch_pc_d = REDIRECT_PC;
            inflight_d = 1'b0;
        end else if (SRAM_RD) begin
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 1'b1;
        end else begin
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            last_op_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            last_op_q     <= last_op_d;
        end
    end

    sm83_byte_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (PC_W)
    ) u_fifo (
        .clock      (CLOCK),
        .resetn     (RESET),
        .flush      (REDIRECT_VALID),
        .push       (push),
        .push_data  (SRAM_Q),
        .push_tag   (inflight_pc_q),
        .pop        (pop_fire),
        .count      (fifo_count),
        .head_valid (head_valid),
        .head_data  (head_data),
        .head_tag   (head_tag)
    );

    assign SRAM_ADDRESS      = fetch_pc_q[ADDR_W-1:0];
    assign FETCH_PC          = fetch_pc_q;
    assign OP_VALID          = head_valid;
    assign OP_BYTE           = head_data;
    assign OP_PC             = head_tag;
    assign DEBUG_LAST_OPCODE = last_op_q;

endmodule
